// File: rtl/mix_col_seq_if.sv
// mix_col_seq_if: input/output handshakes for the column-serial MixColumns controller.
// LastRound exists only when MIXCOL_BYPASS_EN is defined.
`default_nettype none

interface mix_col_seq_if;
    logic         InValid;
    logic         InReady;
    logic [127:0] DataIn;
    logic         OutValid;
    logic         OutReady;
    logic [127:0] DataOut;
    logic         Busy;
`ifdef MIXCOL_BYPASS_EN
    logic         LastRound;

    modport slave  (input  InValid, DataIn, OutReady, LastRound,
                    output InReady, OutValid, DataOut, Busy);
    modport master (output InValid, DataIn, OutReady, LastRound,
                    input  InReady, OutValid, DataOut, Busy);
`else
    modport slave  (input  InValid, DataIn, OutReady,
                    output InReady, OutValid, DataOut, Busy);
    modport master (output InValid, DataIn, OutReady,
                    input  InReady, OutValid, DataOut, Busy);
`endif
endinterface

`default_nettype wire

// File: rtl/mix_col_seq.sv
// mix_col_seq: AES MixColumns over one shared column unit, one column per cycle.
// Optional MIXCOL_BYPASS_EN adds LastRound, which passes the state through unmixed.
`default_nettype none

module mix_col_seq #(
  parameter int ZERO_IDLE_OUT = 1
) (
  input  logic          Clk,
  input  logic          Rst_n,
  mix_col_seq_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]   r_state;
  logic [1:0]   r_cnt;
  logic [127:0] r_din;
  logic [127:0] r_res;

  logic         w_in_ready;
  logic         w_out_valid;
  logic         w_accept;
  logic         w_xfer;
  logic         w_bypass;
  logic [31:0]  w_col;
  logic [31:0]  w_mix;

  function automatic logic [7:0] f_xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] f_mix(input logic [31:0] c);
    logic [7:0] s0, s1, s2, s3;
    logic [7:0] t0, t1, t2, t3;
    s0 = c[31:24]; s1 = c[23:16]; s2 = c[15:8]; s3 = c[7:0];
    t0 = f_xt(s0); t1 = f_xt(s1); t2 = f_xt(s2); t3 = f_xt(s3);
    // 3x = 2x ^ x
    return {t0 ^ t1 ^ s1 ^ s2 ^ s3,
            s0 ^ t1 ^ t2 ^ s2 ^ s3,
            s0 ^ s1 ^ t2 ^ t3 ^ s3,
            t0 ^ s0 ^ s1 ^ s2 ^ t3};
  endfunction

  assign w_out_valid = (r_state == DONE);
  assign w_in_ready  = (r_state == IDLE) || ((r_state == DONE) && bus.OutReady);
  assign w_accept    = bus.InValid && w_in_ready;
  assign w_xfer      = w_out_valid && bus.OutReady;

`ifdef MIXCOL_BYPASS_EN
  assign w_bypass = bus.LastRound;
`else
  assign w_bypass = 1'b0;
`endif

  always_comb begin
    w_col = r_din[127:96];
    case (r_cnt)
      2'd0:    w_col = r_din[127:96];
      2'd1:    w_col = r_din[95:64];
      2'd2:    w_col = r_din[63:32];
      default: w_col = r_din[31:0];
    endcase
  end

  assign w_mix = f_mix(w_col);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
      r_din   <= '0;
      r_res   <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_din <= bus.DataIn;
            r_cnt <= 2'd0;
            if (w_bypass) begin
              r_res   <= bus.DataIn;
              r_state <= DONE;
            end else begin
              r_state <= BUSY;
            end
          end else if (w_xfer) begin
            r_state <= IDLE;
          end
        end
        BUSY: begin
          case (r_cnt)
            2'd0:    r_res[127:96] <= w_mix;
            2'd1:    r_res[95:64]  <= w_mix;
            2'd2:    r_res[63:32]  <= w_mix;
            default: r_res[31:0]   <= w_mix;
          endcase
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.InReady  = w_in_ready;
  assign bus.OutValid = w_out_valid;
  assign bus.Busy     = (r_state == BUSY);
  assign bus.DataOut  = ((ZERO_IDLE_OUT != 0) && !w_out_valid) ? 128'h0 : r_res;

endmodule

`default_nettype wire

// File: tb/tb_mix_col_seq.sv
// tb_mix_col_seq: directed-vector bench for mix_col_seq with hand-computed MixColumns results.
`default_nettype none

module tb_mix_col_seq;

  localparam logic [127:0] V1  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] R1  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V2  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] R2  = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
  localparam logic [127:0] VBP = 128'h0123456789abcdef_fedcba9876543210;

  logic Clk   = 1'b0;
  logic Rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  mix_col_seq_if bus ();

  mix_col_seq #(.ZERO_IDLE_OUT(1)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input logic [127:0] d);
    bus.InValid = 1'b1;
    bus.DataIn  = d;
    step();
    bus.InValid = 1'b0;
  endtask

  // Cycles from the current point until OutValid, bounded.
  task automatic wait_out(output int n);
    n = 0;
    while (!bus.OutValid && n < 20) begin
      step();
      n++;
    end
  endtask

  int  n;
  bit  stable;

  initial begin
    bus.InValid  = 1'b0;
    bus.DataIn   = '0;
    bus.OutReady = 1'b0;
`ifdef MIXCOL_BYPASS_EN
    bus.LastRound = 1'b0;
`endif
    #12;
    chk("rst_inready",  128'(bus.InReady),  128'd1);
    chk("rst_outvalid", 128'(bus.OutValid), 128'd0);
    chk("rst_busy",     128'(bus.Busy),     128'd0);
    chk("rst_dataout",  bus.DataOut,        128'd0);
    Rst_n = 1'b1;
    step();

    // 1: single block
    bus.OutReady = 1'b1;
    send(V1);
    chk("t1_busy",    128'(bus.Busy),    128'd1);
    chk("t1_inready", 128'(bus.InReady), 128'd0);
    wait_out(n);
    chk("t1_latency", 128'(n), 128'd4);
    chk("t1_data",    bus.DataOut, R1);
    step();
    chk("t1_valid_drop", 128'(bus.OutValid), 128'd0);
    chk("t1_zero_idle",  bus.DataOut, 128'd0);

    // 2: backpressure
    bus.OutReady = 1'b0;
    send(V2);
    wait_out(n);
    chk("t2_latency", 128'(n), 128'd4);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus.DataOut !== R2 || bus.InReady !== 1'b0 || bus.OutValid !== 1'b1) stable = 1'b0;
      step();
    end
    chk("t2_hold", 128'(stable), 128'd1);
    chk("t2_data", bus.DataOut, R2);
    bus.OutReady = 1'b1;
    #1;
    chk("t2_inready_follow", 128'(bus.InReady), 128'd1);
    step();
    chk("t2_xfer", 128'(bus.OutValid), 128'd0);

    // 3: back-to-back, second accept overlaps first transfer
    bus.InValid = 1'b1;
    bus.DataIn  = V1;
    step();
    bus.DataIn = V2;
    wait_out(n);
    chk("t3_lat_a",  128'(n), 128'd4);
    chk("t3_data_a", bus.DataOut, R1);
    chk("t3_overlap_ready", 128'(bus.InReady), 128'd1);
    step();
    bus.InValid = 1'b0;
    chk("t3_busy_b", 128'(bus.Busy), 128'd1);
    wait_out(n);
    chk("t3_lat_b",  128'(n + 1), 128'd5);
    chk("t3_data_b", bus.DataOut, R2);
    step();
    chk("t3_idle", 128'(bus.OutValid), 128'd0);

    // 4: DataIn/InValid noise during BUSY
    bus.OutReady = 1'b0;
    send(V1);
    for (int i = 0; i < 4; i++) begin
      bus.DataIn  = {$urandom, $urandom, $urandom, $urandom};
      bus.InValid = 1'($urandom);
      step();
    end
    bus.InValid = 1'b0;
    chk("t4_valid", 128'(bus.OutValid), 128'd1);
    chk("t4_data",  bus.DataOut, R1);
    bus.OutReady = 1'b1;
    step();

    // 5: async reset at counter=2
    send(V2);
    step();
    step();
    #2;
    Rst_n = 1'b0;
    #1;
    chk("t5_busy_async",  128'(bus.Busy),     128'd0);
    chk("t5_valid_async", 128'(bus.OutValid), 128'd0);
    chk("t5_data_async",  bus.DataOut,        128'd0);
    chk("t5_ready_async", 128'(bus.InReady),  128'd1);
    #2;
    Rst_n = 1'b1;
    step();
    send(V1);
    wait_out(n);
    chk("t5_lat",  128'(n), 128'd4);
    chk("t5_data", bus.DataOut, R1);
    step();

`ifdef MIXCOL_BYPASS_EN
    // 6: final-round bypass
    bus.LastRound = 1'b1;
    send(VBP);
    bus.LastRound = 1'b0;
    chk("t6_bp_valid", 128'(bus.OutValid), 128'd1);
    chk("t6_bp_data",  bus.DataOut, VBP);
    step();
    send(V2);
    wait_out(n);
    chk("t6_mix_lat",  128'(n), 128'd4);
    chk("t6_mix_data", bus.DataOut, R2);
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
